carrier_mask_event_gen: RTL and testbench

- Carrier counter and mask-event source for one PWM channel group.
- Produces the `maskevent` strobe and the `pwm_onoff` context consumed by the shadow/mask registers.
- Those registers hold compare and period values until the next carrier boundary. This block drives that boundary.
- Runs a sawtooth or triangular carrier from a shadowed period. It emits single-cycle mask events at carrier min and/or max, selected by mask mode.

---
 rtl/carrier_mask_event_gen.sv | 179 +++++++++++++++++
 tb/tb_carrier_mask_event_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_mask_event_gen.sv
// carrier_mask_event_gen
//   Carrier counter and mask-event source for one PWM channel group.
//   Runs an up-sawtooth, down-sawtooth or up/down triangle carrier from a
//   shadowed period. Emits a registered single-cycle maskevent at carrier
//   min and/or max as selected live by mask_mode. The period and carrier
//   mode are re-sampled only at the carrier reload point while running.
//
//   Optional build macro MASK_PRESCALE_EN adds the mask_div input. With it,
//   maskevent fires on every (mask_div+1)-th qualifying boundary only. The
//   first boundary after start always fires. mask_div is shadowed with the
//   period.
module carrier_mask_event_gen #(
  parameter int PWMCOUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pwm_onoff,
  input  logic [1:0]                carr_mode,
  input  logic [1:0]                mask_mode,
  input  logic [PWMCOUNT_WIDTH-1:0] period_in,
`ifdef MASK_PRESCALE_EN
  input  logic [3:0]                mask_div,
`endif
  output logic [PWMCOUNT_WIDTH-1:0] count_out,
  output logic                      dir_out,
  output logic                      carr_zero,
  output logic                      carr_peak,
  output logic                      maskevent
);

  localparam int             W         = PWMCOUNT_WIDTH;
  localparam logic [W-1:0]   CNT_ZERO  = '0;
  localparam logic [W-1:0]   CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [1:0]     MODE_DOWN = 2'b01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_e;

  state_e       state_q;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] period_sh_q, period_sh_d;
  logic [1:0]   mode_sh_q, mode_sh_d;
  logic         dir_q, dir_d;
  logic         zero_q, peak_q, mev_q;
  logic [W-1:0] step_cnt;
  logic         step_down;
  logic         wrap;
  logic         reload;
  logic         qual;
  logic         fire;

  // One carrier step from the current count under the shadowed period/mode.
  // wrap marks the step that crosses into a new carrier period.
  always_comb begin
    wrap      = 1'b0;
    step_cnt  = count_q;
    step_down = 1'b0;
    if (mode_sh_q[1]) begin
      // triangle (mode 11 behaves as 10)
      if (state_q == RUN_DOWN) begin
        if (count_q <= CNT_ONE) begin
          wrap = 1'b1;
        end else begin
          step_cnt  = count_q - CNT_ONE;
          step_down = 1'b1;
        end
      end else if (count_q >= period_sh_q) begin
        // at the peak: P of 0 or 1 has no falling half
        if (period_sh_q <= CNT_ONE) begin
          wrap = 1'b1;
        end else begin
          step_cnt  = period_sh_q - CNT_ONE;
          step_down = 1'b1;
        end
      end else begin
        step_cnt = count_q + CNT_ONE;
      end
    end else if (mode_sh_q == MODE_DOWN) begin
      if (count_q == CNT_ZERO) begin
        wrap = 1'b1;
      end else begin
        step_cnt  = count_q - CNT_ONE;
        step_down = 1'b1;
      end
    end else begin
      if (count_q >= period_sh_q) wrap = 1'b1;
      else                        step_cnt = count_q + CNT_ONE;
    end
  end

  // Next count while running. Leaving IDLE and wrapping are the same event:
  // re-sample period/mode and start at the new mode's first value.
  always_comb begin
    reload      = (state_q == IDLE) || wrap;
    period_sh_d = reload ? period_in : period_sh_q;
    mode_sh_d   = reload ? carr_mode : mode_sh_q;
    if (reload) begin
      count_d = (carr_mode == MODE_DOWN) ? period_in : CNT_ZERO;
      dir_d   = (carr_mode == MODE_DOWN);
    end else begin
      count_d = step_cnt;
      dir_d   = step_down;
    end
    qual = (mask_mode[0] && (count_d == CNT_ZERO)) ||
           (mask_mode[1] && (count_d == period_sh_d));
  end

`ifdef MASK_PRESCALE_EN
  logic [3:0] div_sh_q, div_sh_d;
  logic [3:0] ev_cnt_q, ev_cnt_d;

  // Divide qualifying boundaries; event counter 0 means "fire this one".
  always_comb begin
    div_sh_d = reload ? mask_div : div_sh_q;
    ev_cnt_d = ev_cnt_q;
    if (qual) ev_cnt_d = (ev_cnt_q >= div_sh_d) ? 4'd0 : ev_cnt_q + 4'd1;
    fire = qual && (ev_cnt_q == 4'd0);
  end

  // Prescale shadow and event counter; cleared whenever the carrier is off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_sh_q <= 4'd0;
      ev_cnt_q <= 4'd0;
    end else if (!pwm_onoff) begin
      div_sh_q <= mask_div;
      ev_cnt_q <= 4'd0;
    end else begin
      div_sh_q <= div_sh_d;
      ev_cnt_q <= ev_cnt_d;
    end
  end
`else
  assign fire = qual;
`endif

  // Carrier FSM: IDLE holds everything at zero and tracks the inputs into the
  // shadows; RUN_UP/RUN_DOWN follow the counting direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= CNT_ZERO;
      dir_q       <= 1'b0;
      zero_q      <= 1'b0;
      peak_q      <= 1'b0;
      mev_q       <= 1'b0;
      period_sh_q <= CNT_ZERO;
      mode_sh_q   <= 2'b00;
    end else if (!pwm_onoff) begin
      state_q     <= IDLE;
      count_q     <= CNT_ZERO;
      dir_q       <= 1'b0;
      zero_q      <= 1'b0;
      peak_q      <= 1'b0;
      mev_q       <= 1'b0;
      period_sh_q <= period_in;
      mode_sh_q   <= carr_mode;
    end else begin
      state_q     <= dir_d ? RUN_DOWN : RUN_UP;
      count_q     <= count_d;
      dir_q       <= dir_d;
      zero_q      <= (count_d == CNT_ZERO);
      peak_q      <= (count_d == period_sh_d);
      mev_q       <= fire;
      period_sh_q <= period_sh_d;
      mode_sh_q   <= mode_sh_d;
    end
  end

  assign count_out = count_q;
  assign dir_out   = dir_q;
  assign carr_zero = zero_q;
  assign carr_peak = peak_q;
  assign maskevent = mev_q;

endmodule

// File: tb/tb_carrier_mask_event_gen.sv
// Scoreboard bench for carrier_mask_event_gen. The reference model tracks
// the carrier as a phase index inside the current period and derives the
// count, direction and flags from it arithmetically.
`timescale 1ns/1ps
module tb_carrier_mask_event_gen;
  localparam int W = 16;

`ifdef MASK_PRESCALE_EN
  localparam bit PRESCALE = 1'b1;
`else
  localparam bit PRESCALE = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         dir;
    logic         zero;
    logic         peak;
    logic         ev;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm_onoff = 1'b0;
  logic [1:0]   carr_mode = 2'b00;
  logic [1:0]   mask_mode = 2'b00;
  logic [W-1:0] period_in = '0;
  logic [3:0]   mask_div = 4'd0;
  logic [W-1:0] count_out;
  logic         dir_out, carr_zero, carr_peak, maskevent;

  carrier_mask_event_gen #(.PWMCOUNT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_onoff (pwm_onoff),
    .carr_mode (carr_mode),
    .mask_mode (mask_mode),
    .period_in (period_in),
`ifdef MASK_PRESCALE_EN
    .mask_div  (mask_div),
`endif
    .count_out (count_out),
    .dir_out   (dir_out),
    .carr_zero (carr_zero),
    .carr_peak (carr_peak),
    .maskevent (maskevent)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];
  logic rst_val = 1'b0;

  // reference model state
  bit       m_run = 1'b0;
  int       m_P = 0;
  int       m_k = 0;
  int       m_div = 0;
  int       m_evc = 0;
  logic [1:0] m_mode = 2'b00;

  function automatic int plen(input int p, input logic [1:0] m);
    if (m[1]) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  // Expected outputs after the coming clock edge, from the current inputs.
  function automatic exp_t model_step();
    exp_t e = '0;
    int   c;
    logic d, z, pk, qual;
    if (!reset) begin
      m_run = 1'b0; m_P = 0; m_mode = 2'b00; m_div = 0; m_k = 0; m_evc = 0;
      return e;
    end
    if (!pwm_onoff) begin
      m_run = 1'b0; m_P = int'(period_in); m_mode = carr_mode;
      m_div = int'(mask_div); m_k = 0; m_evc = 0;
      return e;
    end
    if (!m_run || (m_k + 1 >= plen(m_P, m_mode))) begin
      m_P = int'(period_in); m_mode = carr_mode; m_div = int'(mask_div);
      m_k = 0; m_run = 1'b1;
    end else begin
      m_k++;
    end
    if (m_mode[1]) begin
      c = (m_k <= m_P) ? m_k : 2 * m_P - m_k;
      d = (m_k > m_P);
    end else if (m_mode == 2'b01) begin
      c = m_P - m_k;
      d = 1'b1;
    end else begin
      c = m_k;
      d = 1'b0;
    end
    z    = (c == 0);
    pk   = (c == m_P);
    qual = (mask_mode[0] && z) || (mask_mode[1] && pk);
    e.ev = qual && (m_evc == 0);
    if (qual) m_evc = (m_evc >= m_div) ? 0 : m_evc + 1;
    e.cnt  = c[W-1:0];
    e.dir  = d;
    e.zero = z;
    e.peak = pk;
    return e;
  endfunction

  task automatic drv(input logic on, input logic [1:0] cm, input logic [1:0] mm,
                     input logic [W-1:0] pin, input logic [3:0] dv);
    @(negedge clk);
    reset     = rst_val;
    pwm_onoff = on;
    carr_mode = cm;
    mask_mode = mm;
    period_in = pin;
    mask_div  = PRESCALE ? dv : 4'd0;
    q.push_back(model_step());
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drv(pwm_onoff, carr_mode, mask_mode, period_in, mask_div);
  endtask

  task automatic check_now(input string name);
    exp_t got;
    got = {count_out, dir_out, carr_zero, carr_peak, maskevent};
    nvec++;
    if (got !== '0) begin
      nerr++;
      $display("FAIL %s t=%0t got cnt=%0d dir=%b z=%b pk=%b ev=%b want all zero",
               name, $time, got.cnt, got.dir, got.zero, got.peak, got.ev);
    end
  endtask

  // Reset asserted between edges must clear the outputs at once.
  task automatic async_rst();
    @(negedge clk);
    #2;
    rst_val = 1'b0;
    reset   = 1'b0;
    #1;
    check_now("async_reset");
    q.push_back(model_step());
  endtask

  // monitor: one expectation per clock edge once stimulus is flowing
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {count_out, dir_out, carr_zero, carr_peak, maskevent};
        nvec++;
        if (got !== e) begin
          nerr++;
          $display("FAIL carrier t=%0t got cnt=%0d dir=%b z=%b pk=%b ev=%b exp cnt=%0d dir=%b z=%b pk=%b ev=%b",
                   $time, got.cnt, got.dir, got.zero, got.peak, got.ev,
                   e.cnt, e.dir, e.zero, e.peak, e.ev);
        end
      end
    end
  end

  initial begin
    logic [1:0]   cm, mm;
    logic [W-1:0] pin;
    logic [3:0]   dv;
    int           len, r;

    #1 reset = 1'b0;
    #1 check_now("reset_state");
    drv(1'b1, 2'b00, 2'b01, 16'd4, 4'd0);   // reset still low: outputs held
    rst_val = 1'b1;

    // up, P=4, mask at min
    drv(1'b1, 2'b00, 2'b01, 16'd4, 4'd0); hold(11);
    drv(1'b0, 2'b00, 2'b01, 16'd4, 4'd0);
    // triangle, P=3, both events
    drv(1'b1, 2'b10, 2'b11, 16'd3, 4'd0); hold(13);
    drv(1'b0, 2'b10, 2'b11, 16'd3, 4'd0);
    // up P=10, period_in moved to 5 mid-period at count 3
    drv(1'b1, 2'b00, 2'b11, 16'd10, 4'd0); hold(3);
    drv(1'b1, 2'b00, 2'b11, 16'd5, 4'd0); hold(16);
    drv(1'b0, 2'b00, 2'b11, 16'd5, 4'd0);
    // down P=2, event at max
    drv(1'b1, 2'b01, 2'b10, 16'd2, 4'd0); hold(7);
    // P=0 in each mode, all events
    drv(1'b0, 2'b00, 2'b11, 16'd0, 4'd0);
    drv(1'b1, 2'b00, 2'b11, 16'd0, 4'd0); hold(3);
    drv(1'b0, 2'b01, 2'b11, 16'd0, 4'd0);
    drv(1'b1, 2'b01, 2'b11, 16'd0, 4'd0); hold(3);
    drv(1'b0, 2'b11, 2'b01, 16'd0, 4'd0);
    drv(1'b1, 2'b11, 2'b01, 16'd0, 4'd0); hold(3);
    // all-ones period
    drv(1'b0, 2'b01, 2'b11, 16'hFFFF, 4'd0);
    drv(1'b1, 2'b01, 2'b11, 16'hFFFF, 4'd0); hold(4);
    drv(1'b0, 2'b10, 2'b11, 16'hFFFF, 4'd0);
    drv(1'b1, 2'b10, 2'b11, 16'hFFFF, 4'd0); hold(4);
    // off at count 7, restart, then reset mid-run and restart from 0
    drv(1'b0, 2'b00, 2'b01, 16'd10, 4'd0);
    drv(1'b1, 2'b00, 2'b01, 16'd10, 4'd0); hold(7);
    drv(1'b0, 2'b00, 2'b01, 16'd10, 4'd0); hold(1);
    drv(1'b1, 2'b00, 2'b01, 16'd10, 4'd0); hold(4);
    async_rst();
    hold(2);
    rst_val = 1'b1;
    hold(5);
    // prescaled events: fire on 1st, 4th, 7th zero
    if (PRESCALE) begin
      drv(1'b0, 2'b00, 2'b01, 16'd3, 4'd2);
      drv(1'b1, 2'b00, 2'b01, 16'd3, 4'd2); hold(30);
    end

    // randomized segments with mid-period input churn
    for (int s = 0; s < 40; s++) begin
      cm  = 2'($urandom_range(0, 3));
      mm  = 2'($urandom_range(0, 3));
      r   = $urandom_range(0, 9);
      pin = (r == 0) ? 16'hFFFF : (r == 1) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 7));
      dv  = 4'($urandom_range(0, 3));
      drv(1'b0, cm, mm, pin, dv);
      len = $urandom_range(10, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) pin = W'($urandom_range(0, 7));
        if ($urandom_range(0, 4) == 0) cm  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) mm  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) dv  = 4'($urandom_range(0, 3));
        drv(($urandom_range(0, 32) != 0), cm, mm, pin, dv);
      end
      if ($urandom_range(0, 7) == 0) begin
        async_rst();
        hold(1);
        rst_val = 1'b1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
